fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 37 +++
 rtl/fetch_buffer.sv | 36 +++
 rtl/fetch_stage.sv | 175 +++++++++++++++++
 tb/tb_fetch_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_pkg
//  Purpose  : Shared pipeline definitions: fetch FSM states, bubble word,
//             reset fetch address and RV32I major opcodes used by decode.
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] c_nop_inst = 32'h0000_0013;
    localparam logic [31:0] c_reset_pc = 32'h0000_0000;

    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_system = 7'b1110011;

    // Instruction fetches are word granular; low address bits are discarded.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_buffer
//  Purpose  : One-entry skid buffer holding a fetched word while decode stalls.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] EMPTY_VALUE = c_nop_inst
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] din,
    output logic [31:0] dout
);

    logic [31:0] r_data;

    // Clear wins over load so a redirect always discards the parked word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= EMPTY_VALUE;
        end else if (clear) begin
            r_data <= EMPTY_VALUE;
        end else if (load) begin
            r_data <= din;
        end
    end

    assign dout = r_data;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction fetch: PC sequencing, single-outstanding memory
//             request FSM, stall/redirect handling and the IF/ID register.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc,
    parameter logic [31:0] NOP_INST = c_nop_inst
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [31:0] r_pc;
    logic        r_discard;
    logic        r_if_valid;
    logic [31:0] r_if_inst;
    logic [31:0] r_if_pc;

    logic [31:0] w_pc_nxt;
    logic        w_discard_nxt;
    logic        w_if_valid_nxt;
    logic [31:0] w_if_inst_nxt;
    logic [31:0] w_if_pc_nxt;
    logic        w_deliver;
    logic [31:0] w_deliver_inst;
    logic        w_buf_load;
    logic        w_buf_clear;
    logic [31:0] w_buf_data;
    logic [31:0] w_redirect_pc;

    assign w_redirect_pc = word_align(redirect_pc);

    fetch_buffer #(
        .EMPTY_VALUE (NOP_INST)
    ) u_fetch_buffer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_buf_load),
        .clear (w_buf_clear),
        .din   (imem_rdata),
        .dout  (w_buf_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_discard  <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_inst  <= NOP_INST;
            r_if_pc    <= 32'h0000_0000;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_discard  <= w_discard_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_if_inst  <= w_if_inst_nxt;
            r_if_pc    <= w_if_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_discard_nxt  = r_discard;
        w_if_valid_nxt = r_if_valid;
        w_if_inst_nxt  = r_if_inst;
        w_if_pc_nxt    = r_if_pc;
        w_deliver      = 1'b0;
        w_deliver_inst = imem_rdata;
        w_buf_load     = 1'b0;
        w_buf_clear    = 1'b0;

        if (redirect_valid) begin
            // Redirect overrides stall: flush IF/ID and restart at the target.
            w_pc_nxt       = w_redirect_pc;
            w_if_valid_nxt = 1'b0;
            w_if_inst_nxt  = NOP_INST;
            case (r_state)
                S_IDLE: w_state_nxt = S_REQ;
                S_REQ: begin
                    if (imem_ready) begin
                        w_discard_nxt = 1'b1;
                        w_state_nxt   = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = S_REQ;
                    end else begin
                        w_discard_nxt = 1'b1;
                    end
                end
                S_HOLD: begin
                    w_buf_clear = 1'b1;
                    w_state_nxt = S_REQ;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_REQ;
                S_REQ: begin
                    if (imem_ready) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_discard) begin
                            // Response belongs to a pre-redirect request.
                            w_discard_nxt = 1'b0;
                            w_state_nxt   = S_REQ;
                        end else if (stall) begin
                            w_buf_load  = 1'b1;
                            w_state_nxt = S_HOLD;
                        end else begin
                            w_deliver   = 1'b1;
                            w_state_nxt = S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        w_deliver      = 1'b1;
                        w_deliver_inst = w_buf_data;
                        w_buf_clear    = 1'b1;
                        w_state_nxt    = S_REQ;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase

            if (w_deliver) begin
                w_if_valid_nxt = 1'b1;
                w_if_inst_nxt  = w_deliver_inst;
                w_if_pc_nxt    = r_pc;
                w_pc_nxt       = r_pc + 32'd4;
            end else if (!stall) begin
                w_if_valid_nxt = 1'b0;
                w_if_inst_nxt  = NOP_INST;
            end
        end
    end

    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = r_pc;
    assign if_id_valid = r_if_valid;
    assign if_id_inst  = r_if_inst;
    assign if_id_pc    = r_if_pc;
    assign if_id_pc4   = r_if_pc + 32'd4;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Self-checking bench for fetch_stage: directed scenarios plus a
//             randomized run against a transaction-level fetch-stream model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect_valid, imem_ready, imem_rvalid;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, if_id_valid;
    logic [31:0] imem_addr, if_id_inst, if_id_pc, if_id_pc4;

    logic        ready_w, rvalid_w, req_w, valid_w;
    logic [31:0] rdata_w, addr_w, inst_w, pc_w, pc4_w;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_stage u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_id_valid(if_id_valid), .if_id_inst(if_id_inst),
        .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .stall(1'b0),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imem_req(req_w), .imem_addr(addr_w), .imem_ready(ready_w),
        .imem_rvalid(rvalid_w), .imem_rdata(rdata_w),
        .if_id_valid(valid_w), .if_id_inst(inst_w),
        .if_id_pc(pc_w), .if_id_pc4(pc4_w)
    );

    // Memory contents as seen by the reference model: a fixed hash of the address.
    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        ready_w = 1'b0; rvalid_w = 1'b0; rdata_w = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        cyc(); cyc();
        n_tests++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", if_id_valid); end
        n_tests++; if (if_id_inst !== NOP) begin n_fail++; $display("FAIL reset_inst: got %h want %h", if_id_inst, NOP); end
        n_tests++; if (if_id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", if_id_pc); end
        n_tests++; if (if_id_pc4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc4: got %h want 4", if_id_pc4); end
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", imem_req); end
        n_tests++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_basic();
        imem_ready = 1'b1;
        rst_n = 1'b1;
        cyc();
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL basic_req0: req %0b addr %h want 1/0", imem_req, imem_addr); end
        cyc();
        n_tests++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early: valid %0b want 0", if_id_valid); end
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        cyc();
        imem_rvalid = 1'b0;
        n_tests++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_inst !== 32'h0050_0093 || if_id_pc4 !== 32'h4)
            begin n_fail++; $display("FAIL basic_d0: valid %0b pc %h inst %h pc4 %h want 1/0/00500093/4", if_id_valid, if_id_pc, if_id_inst, if_id_pc4); end
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL basic_req1: req %0b addr %h want 1/4", imem_req, imem_addr); end
        cyc();
        imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
        cyc();
        imem_rvalid = 1'b0;
        n_tests++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h4 || if_id_inst !== 32'h00A0_0113)
            begin n_fail++; $display("FAIL basic_d1: valid %0b pc %h inst %h want 1/4/00a00113", if_id_valid, if_id_pc, if_id_inst); end
    endtask

    task automatic test_stall();
        logic        pv;
        logic [31:0] pi, pp;
        cyc();
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_wait: req %0b want 0", imem_req); end
        stall = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
        pv = if_id_valid; pi = if_id_inst; pp = if_id_pc;
        for (int i = 0; i < 3; i++) begin
            cyc();
            imem_rvalid = 1'b0;
            n_tests++; if (if_id_valid !== pv || if_id_inst !== pi || if_id_pc !== pp || imem_req !== 1'b0)
                begin n_fail++; $display("FAIL stall_hold%0d: valid %0b inst %h pc %h req %0b want %0b/%h/%h/0", i, if_id_valid, if_id_inst, if_id_pc, imem_req, pv, pi, pp); end
        end
        stall = 1'b0; imem_ready = 1'b0;
        cyc();
        n_tests++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h8 || if_id_inst !== 32'h0000_0013 || if_id_pc4 !== 32'hC)
            begin n_fail++; $display("FAIL stall_release: valid %0b pc %h inst %h pc4 %h want 1/8/13/c", if_id_valid, if_id_pc, if_id_inst, if_id_pc4); end
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_fail++; $display("FAIL stall_next: req %0b addr %h want 1/c", imem_req, imem_addr); end
        cyc();
        n_tests++; if (if_id_valid !== 1'b0 || if_id_inst !== NOP) begin n_fail++; $display("FAIL stall_once: valid %0b inst %h want 0/nop", if_id_valid, if_id_inst); end
    endtask

    task automatic test_redirect_wait();
        imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        cyc();
        redirect_valid = 1'b0;
        n_tests++; if (if_id_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL rdw_flush: valid %0b req %0b want 0/0", if_id_valid, imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        cyc();
        imem_rvalid = 1'b0;
        n_tests++; if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100)
            begin n_fail++; $display("FAIL rdw_drop: valid %0b req %0b addr %h want 0/1/100", if_id_valid, imem_req, imem_addr); end
    endtask

    task automatic test_redirect_hold();
        imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678; stall = 1'b1;
        cyc();
        imem_rvalid = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        cyc();
        redirect_valid = 1'b0; stall = 1'b0;
        n_tests++; if (if_id_valid !== 1'b0 || if_id_inst !== NOP || imem_req !== 1'b1 || imem_addr !== 32'h200)
            begin n_fail++; $display("FAIL rdh_flush: valid %0b inst %h req %0b addr %h want 0/nop/1/200", if_id_valid, if_id_inst, imem_req, imem_addr); end
        cyc();
        n_tests++; if (if_id_valid !== 1'b0) begin n_fail++; $display("FAIL rdh_nobuf: valid %0b inst %h want 0", if_id_valid, if_id_inst); end
        imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
        cyc();
        imem_rvalid = 1'b0;
        n_tests++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h200 || if_id_inst !== 32'h00A0_0113)
            begin n_fail++; $display("FAIL rdh_target: valid %0b pc %h inst %h want 1/200/00a00113", if_id_valid, if_id_pc, if_id_inst); end
    endtask

    task automatic test_async_reset();
        stall = 1'b1; imem_ready = 1'b1;
        cyc();
        n_tests++; if (if_id_valid !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL arst_pre: valid %0b req %0b want 1/0", if_id_valid, imem_req); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (if_id_valid !== 1'b0 || if_id_inst !== NOP || if_id_pc !== 32'h0 || if_id_pc4 !== 32'h4 || imem_req !== 1'b0 || imem_addr !== 32'h0)
            begin n_fail++; $display("FAIL arst_now: valid %0b inst %h pc %h pc4 %h req %0b addr %h", if_id_valid, if_id_inst, if_id_pc, if_id_pc4, imem_req, imem_addr); end
        imem_ready = 1'b0; stall = 1'b0;
        cyc();
        rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        cyc();
        imem_rvalid = 1'b0;
        n_tests++; if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0)
            begin n_fail++; $display("FAIL arst_stale: valid %0b req %0b addr %h want 0/1/0", if_id_valid, imem_req, imem_addr); end
        imem_ready = 1'b1;
        cyc();
        imem_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        cyc();
        imem_rvalid = 1'b0;
        n_tests++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_inst !== 32'h0050_0093)
            begin n_fail++; $display("FAIL arst_first: valid %0b pc %h inst %h want 1/0/00500093", if_id_valid, if_id_pc, if_id_inst); end
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        idle_inputs();
        cyc();
        ready_w = 1'b1; rst_n = 1'b1;
        cyc();
        n_tests++; if (req_w !== 1'b1 || addr_w !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_first: req %0b addr %h want 1/fffffffc", req_w, addr_w); end
        cyc();
        rvalid_w = 1'b1; rdata_w = 32'h0010_0093;
        cyc();
        rvalid_w = 1'b0;
        n_tests++; if (valid_w !== 1'b1 || pc_w !== 32'hFFFF_FFFC || pc4_w !== 32'h0 || inst_w !== 32'h0010_0093)
            begin n_fail++; $display("FAIL wrap_deliver: valid %0b pc %h pc4 %h inst %h want 1/fffffffc/0/00100093", valid_w, pc_w, pc4_w, inst_w); end
        n_tests++; if (req_w !== 1'b1 || addr_w !== 32'h0) begin n_fail++; $display("FAIL wrap_second: req %0b addr %h want 1/0", req_w, addr_w); end
    endtask

    // Transaction model: decode must see the sequential word stream from the
    // last redirect target, each word equal to memory at its address.
    task automatic test_random();
        logic [31:0] exp_pc, pend_addr, rt, acc_addr, pi, pp;
        logic        pv, s, r, rv, acc;
        bit          pending;
        int          lat, deliveries;
        rst_n = 1'b0;
        idle_inputs();
        cyc();
        rst_n = 1'b1;
        exp_pc = 32'h0; pending = 0; lat = 0; deliveries = 0;
        for (int k = 0; k < 4000; k++) begin
            s  = ($urandom % 4) == 0;
            r  = ($urandom % 12) == 0;
            rt = $urandom;
            rv = pending && (lat == 0);
            stall = s; redirect_valid = r; redirect_pc = rt;
            imem_ready = ($urandom % 3) != 0;
            imem_rvalid = rv;
            imem_rdata = rv ? memw(pend_addr) : $urandom;
            #1;
            if (imem_req) begin
                n_tests++; if (imem_addr !== exp_pc) begin n_fail++; $display("FAIL rnd_addr@%0d: got %h want %h", k, imem_addr, exp_pc); end
            end
            if (imem_req && imem_ready && pending) begin
                n_tests++; n_fail++; $display("FAIL rnd_outstanding@%0d: req %0b with response pending, want 0", k, imem_req);
            end
            acc = imem_req && imem_ready;
            acc_addr = imem_addr;
            pv = if_id_valid; pi = if_id_inst; pp = if_id_pc;
            cyc();
            if (rv) pending = 0;
            else if (pending) lat--;
            if (acc) begin pending = 1; pend_addr = acc_addr; lat = $urandom_range(0, 2); end
            n_tests++;
            if (r) begin
                exp_pc = rt & ~32'h3;
                if (if_id_valid !== 1'b0 || if_id_inst !== NOP)
                    begin n_fail++; $display("FAIL rnd_flush@%0d: valid %0b inst %h want 0/nop", k, if_id_valid, if_id_inst); end
            end else if (s) begin
                if (if_id_valid !== pv || if_id_inst !== pi || if_id_pc !== pp)
                    begin n_fail++; $display("FAIL rnd_hold@%0d: %0b/%h/%h want %0b/%h/%h", k, if_id_valid, if_id_inst, if_id_pc, pv, pi, pp); end
            end else if (if_id_valid === 1'b1) begin
                deliveries++;
                if (if_id_pc !== exp_pc || if_id_inst !== memw(exp_pc) || if_id_pc4 !== exp_pc + 32'd4)
                    begin n_fail++; $display("FAIL rnd_deliver@%0d: pc %h inst %h pc4 %h want %h/%h/%h", k, if_id_pc, if_id_inst, if_id_pc4, exp_pc, memw(exp_pc), exp_pc + 32'd4); end
                exp_pc = exp_pc + 32'd4;
            end else begin
                if (if_id_valid !== 1'b0 || if_id_inst !== NOP)
                    begin n_fail++; $display("FAIL rnd_bubble@%0d: valid %0b inst %h want 0/nop", k, if_id_valid, if_id_inst); end
            end
        end
        n_tests++; if (deliveries < 200) begin n_fail++; $display("FAIL rnd_progress: got %0d deliveries want >=200", deliveries); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_async_reset();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
